// File: rtl/crossbar_output_arbiter_if.sv
// rtl/crossbar_output_arbiter_if.sv - request/grant bundle between fabric sources and one crossbar output arbiter
interface crossbar_output_arbiter_if #(
    parameter int NUM_SRC = 28
);
    logic [NUM_SRC-1:0] req;
    logic               dst_ready;
    logic               done;
    logic               grant_valid;
    logic [4:0]         grant_src;
    logic [NUM_SRC-1:0] grant_onehot;
    logic               timeout;

    modport master (
        output req, dst_ready, done,
        input  grant_valid, grant_src, grant_onehot, timeout
    );

    modport slave (
        input  req, dst_ready, done,
        output grant_valid, grant_src, grant_onehot, timeout
    );
endinterface

// File: rtl/crossbar_output_arbiter.sv
// rtl/crossbar_output_arbiter.sv - round-robin owner selection for one crossbar output with gap and grant timeout
module crossbar_output_arbiter #(
    parameter int NUM_SRC        = 28,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    crossbar_output_arbiter_if.slave  xbar
);
    localparam logic [4:0] INVALID_PORT = 5'd31;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

    state_t             r_state,   w_state_nxt;
    logic               r_arm;
    logic [4:0]         r_rr_ptr,  w_rr_ptr_nxt;
    logic [15:0]        r_cnt,     w_cnt_nxt;
    logic [3:0]         r_gap,     w_gap_nxt;
    logic               r_valid,   w_valid_nxt;
    logic [4:0]         r_src,     w_src_nxt;
    logic [NUM_SRC-1:0] r_onehot,  w_onehot_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic               w_found;
    logic [4:0]         w_sel;
    logic [5:0]         w_idx;
    logic [NUM_SRC-1:0] w_sel_onehot;

    // First requesting source at or above rr_ptr, wrapping past NUM_SRC-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_idx = 6'(r_rr_ptr) + 6'(i);
            if (w_idx >= 6'(NUM_SRC)) begin
                w_idx = w_idx - 6'(NUM_SRC);
            end
            if (!w_found && xbar.req[w_idx[4:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[4:0];
            end
        end
    end

    assign w_sel_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_arm     <= 1'b0;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_valid   <= 1'b0;
            r_src     <= INVALID_PORT;
            r_onehot  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm     <= 1'b1;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_valid   <= w_valid_nxt;
            r_src     <= w_src_nxt;
            r_onehot  <= w_onehot_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // r_arm holds off arbitration for the first edge after reset release.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = r_gap;
        w_valid_nxt   = r_valid;
        w_src_nxt     = r_src;
        w_onehot_nxt  = r_onehot;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_arm && xbar.dst_ready && w_found) begin
                    w_state_nxt  = ST_GRANT;
                    w_valid_nxt  = 1'b1;
                    w_src_nxt    = w_sel;
                    w_onehot_nxt = w_sel_onehot;
                    w_rr_ptr_nxt = (w_sel == 5'(NUM_SRC-1)) ? 5'd0 : w_sel + 5'd1;
                    w_cnt_nxt    = '0;
                end
            end
            ST_GRANT: begin
                if (xbar.done || (r_cnt == 16'(TIMEOUT_CYCLES-1))) begin
                    w_state_nxt   = ST_GAP;
                    w_valid_nxt   = 1'b0;
                    w_src_nxt     = INVALID_PORT;
                    w_onehot_nxt  = '0;
                    w_gap_nxt     = '0;
                    w_timeout_nxt = !xbar.done;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_GAP: begin
                if (r_gap == 4'(GAP_CYCLES-1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign xbar.grant_valid  = r_valid;
    assign xbar.grant_src    = r_src;
    assign xbar.grant_onehot = r_onehot;
    assign xbar.timeout      = r_timeout;
endmodule

// File: tb/tb_crossbar_output_arbiter.sv
// tb/tb_crossbar_output_arbiter.sv - directed self-checking bench for crossbar_output_arbiter
module tb_crossbar_output_arbiter;
    localparam int NUM_SRC = 28;
    localparam int GAP     = 2;
    localparam int TMO     = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lows;

    crossbar_output_arbiter_if #(.NUM_SRC(NUM_SRC)) xif ();

    crossbar_output_arbiter #(
        .NUM_SRC        (NUM_SRC),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xbar  (xif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant(output int n_low);
        n_low = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (xif.grant_valid) return;
            n_low++;
        end
        chk("grant_wait", {31'd0, xif.grant_valid}, 32'd1);
    endtask

    // One-cycle grant: done during the first visible GRANT cycle, then check the release.
    task automatic finish_grant();
        xif.done = 1'b1;
        tick();
        xif.done = 1'b0;
        chk("release_valid", {31'd0, xif.grant_valid}, 32'd0);
    endtask

    task automatic expect_grant(input string tag, input int src);
        chk(tag, {27'd0, xif.grant_src}, 32'(src));
        chk({tag, "_oh"}, 32'(xif.grant_onehot), 32'd1 << src);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        xif.req       = '0;
        xif.dst_ready = 1'b0;
        xif.done      = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid",   {31'd0, xif.grant_valid}, 32'd0);
        chk("rst_src",     {27'd0, xif.grant_src},   32'd31);
        chk("rst_onehot",  32'(xif.grant_onehot),    32'd0);
        chk("rst_timeout", {31'd0, xif.timeout},     32'd0);

        // Fairness: sources 3, 7, 20 held; release at the negedge, so first edge only arms.
        xif.req       = (28'd1 << 3) | (28'd1 << 7) | (28'd1 << 20);
        xif.dst_ready = 1'b1;
        rst_n         = 1'b1;
        tick();
        chk("arm_no_grant", {31'd0, xif.grant_valid}, 32'd0);
        tick();
        chk("first_grant_valid", {31'd0, xif.grant_valid}, 32'd1);
        expect_grant("fair0", 3);
        finish_grant();
        wait_grant(lows);
        chk("fair_gap1", 32'(lows), 32'(GAP));
        expect_grant("fair1", 7);
        finish_grant();
        wait_grant(lows);
        chk("fair_gap2", 32'(lows), 32'(GAP));
        expect_grant("fair2", 20);
        finish_grant();
        wait_grant(lows);
        chk("fair_gap3", 32'(lows), 32'(GAP));
        expect_grant("fair3", 3);

        // Wrap-around: grant 26 leaves rr_ptr at 27, then 27 and 0 compete.
        xif.req = 28'd1 << 26;
        finish_grant();
        wait_grant(lows);
        expect_grant("wrap26", 26);
        xif.req = (28'd1 << 27) | 28'd1;
        finish_grant();
        wait_grant(lows);
        chk("wrap_gap", 32'(lows), 32'(GAP));
        expect_grant("wrap27", 27);
        finish_grant();
        wait_grant(lows);
        expect_grant("wrap0", 0);
        xif.req = '0;
        finish_grant();
        for (int k = 0; k < 5; k++) tick();

        // Backpressure: no grant while dst_ready is low.
        xif.dst_ready = 1'b0;
        xif.req       = 28'd1 << 5;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold", {31'd0, xif.grant_valid}, 32'd0);
        end
        xif.dst_ready = 1'b1;
        tick();
        chk("bp_valid", {31'd0, xif.grant_valid}, 32'd1);
        expect_grant("bp", 5);
        xif.req = '0;
        finish_grant();
        for (int k = 0; k < 5; k++) tick();

        // Timeout: grantee drops req but keeps the output; forced release after TMO cycles.
        xif.req = 28'd1 << 2;
        wait_grant(lows);
        expect_grant("tmo", 2);
        xif.req = '0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk("tmo_held_src", {27'd0, xif.grant_src}, 32'd2);
            chk("tmo_no_pulse", {31'd0, xif.timeout},   32'd0);
        end
        tick();
        chk("tmo_release", {31'd0, xif.grant_valid}, 32'd0);
        chk("tmo_pulse",   {31'd0, xif.timeout},     32'd1);
        tick();
        chk("tmo_single",  {31'd0, xif.timeout},     32'd0);
        for (int k = 0; k < 5; k++) tick();

        // done on the terminal-count cycle is a normal completion.
        xif.req = 28'd1 << 2;
        wait_grant(lows);
        expect_grant("tc", 2);
        xif.req = '0;
        for (int k = 1; k < TMO; k++) tick();
        chk("tc_still_valid", {31'd0, xif.grant_valid}, 32'd1);
        xif.done = 1'b1;
        tick();
        xif.done = 1'b0;
        chk("tc_release", {31'd0, xif.grant_valid}, 32'd0);
        chk("tc_no_pulse", {31'd0, xif.timeout},    32'd0);
        tick();
        chk("tc_no_pulse2", {31'd0, xif.timeout},   32'd0);
        for (int k = 0; k < 5; k++) tick();

        // Reset mid-grant of source 9; rr_ptr restarts so 9 wins over 10 afterwards.
        xif.req = 28'd1 << 9;
        wait_grant(lows);
        expect_grant("pre_rst", 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid",   {31'd0, xif.grant_valid}, 32'd0);
        chk("async_src",     {27'd0, xif.grant_src},   32'd31);
        chk("async_timeout", {31'd0, xif.timeout},     32'd0);
        xif.req = (28'd1 << 9) | (28'd1 << 10);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(lows);
        chk("post_rst_latency", 32'(lows), 32'd1);
        expect_grant("post_rst", 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
